// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter with rising-edge event counting, saturation and a sticky target flag.
// Optional best-score tracking is built when HIGH_SCORE_EN is defined.
module score_bcd_counter #(
    parameter int MAX_SCORE    = 99,
    parameter int TARGET_SCORE = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLEAR,
    input  logic       EAT_IN,
    output logic [3:0] DIGIT0,
    output logic [3:0] DIGIT1,
    output logic [6:0] SCORE_BIN,
    output logic       TARGET_HIT,
    output logic       SATURATED
`ifdef HIGH_SCORE_EN
    ,
    output logic [3:0] HI_DIGIT0,
    output logic [3:0] HI_DIGIT1,
    output logic       NEW_HIGH
`endif
);

    localparam logic [6:0] MAX_B    = 7'(MAX_SCORE);
    localparam logic [6:0] TARGET_B = 7'(TARGET_SCORE);

    logic       eat_q;
    logic       inc;
    logic       step;
    logic [3:0] nxt_d0;
    logic [3:0] nxt_d1;
    logic [6:0] nxt_bin;

    assign inc       = EAT_IN & ~eat_q;
    assign SATURATED = (SCORE_BIN == MAX_B);
    assign step      = inc & ~CLEAR & ~SATURATED;

    // BCD and binary are advanced side by side so the display path needs no conversion
    always_comb begin
        nxt_bin = SCORE_BIN + 7'd1;
        nxt_d0  = DIGIT0 + 4'd1;
        nxt_d1  = DIGIT1;
        if (DIGIT0 == 4'd9) begin
            nxt_d0 = 4'd0;
            nxt_d1 = DIGIT1 + 4'd1;
        end
    end

    // eat_q resets high so an input already high at reset release is not an event
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            eat_q      <= 1'b1;
            DIGIT0     <= 4'd0;
            DIGIT1     <= 4'd0;
            SCORE_BIN  <= 7'd0;
            TARGET_HIT <= 1'b0;
        end else begin
            eat_q <= EAT_IN;
            if (CLEAR) begin
                DIGIT0     <= 4'd0;
                DIGIT1     <= 4'd0;
                SCORE_BIN  <= 7'd0;
                TARGET_HIT <= 1'b0;
            end else if (step) begin
                DIGIT0    <= nxt_d0;
                DIGIT1    <= nxt_d1;
                SCORE_BIN <= nxt_bin;
                if (nxt_bin == TARGET_B) begin
                    TARGET_HIT <= 1'b1;
                end
            end
        end
    end

`ifdef HIGH_SCORE_EN
    logic [6:0] hi_bin;

    // best score survives CLEAR; only the new-record flag is per game
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hi_bin    <= 7'd0;
            HI_DIGIT0 <= 4'd0;
            HI_DIGIT1 <= 4'd0;
            NEW_HIGH  <= 1'b0;
        end else if (CLEAR) begin
            NEW_HIGH <= 1'b0;
        end else if (step && (nxt_bin > hi_bin)) begin
            hi_bin    <= nxt_bin;
            HI_DIGIT0 <= nxt_d0;
            HI_DIGIT1 <= nxt_d1;
            NEW_HIGH  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter: the driver pushes reference-model results,
// a monitor pops and compares them against the DUT after each clock edge or reset assertion.
module tb_score_bcd_counter;
    localparam int MAX = 99;
    localparam int TGT = 10;

    logic       CLK    = 1'b0;
    logic       RESET  = 1'b0;
    logic       CLEAR  = 1'b0;
    logic       EAT_IN = 1'b1;
    logic [3:0] DIGIT0;
    logic [3:0] DIGIT1;
    logic [6:0] SCORE_BIN;
    logic       TARGET_HIT;
    logic       SATURATED;
`ifdef HIGH_SCORE_EN
    logic [3:0] HI_DIGIT0;
    logic [3:0] HI_DIGIT1;
    logic       NEW_HIGH;
`endif

    score_bcd_counter #(.MAX_SCORE(MAX), .TARGET_SCORE(TGT)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CLEAR      (CLEAR),
        .EAT_IN     (EAT_IN),
        .DIGIT0     (DIGIT0),
        .DIGIT1     (DIGIT1),
        .SCORE_BIN  (SCORE_BIN),
        .TARGET_HIT (TARGET_HIT),
        .SATURATED  (SATURATED)
`ifdef HIGH_SCORE_EN
        ,
        .HI_DIGIT0  (HI_DIGIT0),
        .HI_DIGIT1  (HI_DIGIT1),
        .NEW_HIGH   (NEW_HIGH)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int score;
        bit hit;
        int hi;
        bit nh;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model: plain integer score, digits derived by division
    int m_score, m_hi;
    bit m_eatq, m_hit, m_nh;

    function automatic void model_reset();
        m_score = 0;
        m_hi    = 0;
        m_hit   = 0;
        m_nh    = 0;
        m_eatq  = 1;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.score = m_score;
        e.hit   = m_hit;
        e.hi    = m_hi;
        e.nh    = m_nh;
        q.push_back(e);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit eat, input bit clr, input bit rst);
        bit rise;
        @(negedge CLK);
        EAT_IN = eat;
        CLEAR  = clr;
        RESET  = rst;
        @(posedge CLK);
        if (!rst) begin
            model_reset();
        end else begin
            rise   = eat && !m_eatq;
            m_eatq = eat;
            if (clr) begin
                m_score = 0;
                m_hit   = 0;
                m_nh    = 0;
            end else if (rise && m_score < MAX) begin
                m_score++;
                if (m_score == TGT) m_hit = 1;
                if (m_score > m_hi) begin
                    m_hi = m_score;
                    m_nh = 1;
                end
            end
        end
        #1 push_exp();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 1);
            step(0, 0, 1);
        end
    endtask

    // asynchronous reset dropped mid-cycle, away from both clock edges
    task automatic async_reset(input bit eat);
        @(posedge CLK);
        #3;
        EAT_IN = eat;
        RESET  = 1'b0;
        model_reset();
        push_exp();
    endtask

    always @(posedge CLK or negedge RESET) begin
        #2;
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("digit0", int'(DIGIT0), mon_e.score % 10);
            chk("digit1", int'(DIGIT1), mon_e.score / 10);
            chk("score_bin", int'(SCORE_BIN), mon_e.score);
            chk("target_hit", int'(TARGET_HIT), int'(mon_e.hit));
            chk("saturated", int'(SATURATED), int'(mon_e.score == MAX));
`ifdef HIGH_SCORE_EN
            chk("hi_digit0", int'(HI_DIGIT0), mon_e.hi % 10);
            chk("hi_digit1", int'(HI_DIGIT1), mon_e.hi / 10);
            chk("new_high", int'(NEW_HIGH), int'(mon_e.nh));
`endif
        end
    end

    initial begin
        model_reset();
        #1 push_exp();
        // reset held with EAT_IN high, then released with EAT_IN still high
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (5) step(1, 0, 1);
        step(0, 0, 1);
        // ten pulses through the 9->10 carry and target
        pulses(10);
        // long level counts once
        repeat (20) step(1, 0, 1);
        repeat (2) step(0, 0, 1);
        // run into saturation and beyond
        pulses(105);
        // clear coincident with a rising edge, input held through clear falling
        step(0, 1, 1);
        pulses(47);
        step(1, 1, 1);
        repeat (3) step(1, 0, 1);
        step(0, 0, 1);
        pulses(2);
        // mid-operation reset with input high, then high-score sequence
        async_reset(1);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(0, 0, 1);
        pulses(23);
        step(0, 1, 1);
        pulses(5);
        pulses(19);
        pulses(1);
        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset(1'($urandom_range(0, 1)));
                repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 0, 0);
            end else begin
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0), 1);
            end
        end
        repeat (2) step(0, 0, 1);
        @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
Two-digit BCD score counter for the snake game, directly upstream of the 2-way display digit mux.
- Counts apple-eaten events from the game-control FSM.
- Holds units and tens as separate 4-bit BCD digits. DIGIT0 drives the mux IN1 and DIGIT1 drives IN2, so the display path needs no binary-to-BCD conversion.
- Also flags when the win target is reached.

Parameters:
MAX_SCORE, 99, saturation value in binary; legal range 1..99.
TARGET_SCORE, 10, score at which TARGET_HIT asserts; legal range 1..MAX_SCORE.

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-low reset (0 = reset)
CLEAR  input  1  synchronous clear, new game; active high
EAT_IN  input  1  apple-eaten indication from game FSM; level or pulse, rising-edge counted
DIGIT0  output  4  units BCD digit, 0..9 (to mux IN1)
DIGIT1  output  4  tens BCD digit, 0..9 (to mux IN2)
SCORE_BIN  output  7  same score in binary, 0..99
TARGET_HIT  output  1  sticky flag, score has reached TARGET_SCORE
SATURATED  output  1  high while score == MAX_SCORE

Behaviour:
Clock and reset:
- All state updates on the rising edge of CLK.
- RESET low asynchronously forces DIGIT0=0, DIGIT1=0, SCORE_BIN=0, TARGET_HIT=0 and SATURATED=0.
- RESET low also sets the edge-detect register eat_q=1, so an EAT_IN held high at reset release does not count.

Edge detect:
- eat_q <= EAT_IN every cycle, including cycles where CLEAR is high.
- inc = EAT_IN & ~eat_q.
- An EAT_IN held high for N cycles produces exactly one increment.

Increment (inc=1, CLEAR=0, SCORE_BIN<MAX_SCORE):
- Outputs update on the same edge that samples the rising EAT_IN, i.e. visible 1 cycle after EAT_IN first reads high.
- If DIGIT0==9: DIGIT0 becomes 0 and DIGIT1 becomes DIGIT1+1. Otherwise DIGIT0 becomes DIGIT0+1.
- SCORE_BIN becomes SCORE_BIN+1.
- DIGIT0/DIGIT1 and SCORE_BIN must always agree.

Saturation:
- When SCORE_BIN==MAX_SCORE, inc is ignored and all digits hold.
- SATURATED is combinational from the registered score: (SCORE_BIN==MAX_SCORE).
- There is no wrap to 00.

TARGET_HIT:
- Registered. Set on the same edge the score becomes TARGET_SCORE.
- Stays set while the score increases further.
- Cleared only by CLEAR or RESET.

CLEAR:
- Has priority over inc.
- All score state and TARGET_HIT go to 0 on the next edge.
- A coincident rising EAT_IN is discarded. eat_q still updates, so a pulse straddling CLEAR does not count after CLEAR drops.

Reset mid-operation:
- Immediate return to reset values regardless of CLK.
- The first count after release requires a fresh 0->1 transition on EAT_IN.

Illegal digit codes (>9) are unreachable. The implementation needs no handling for them.

Optional Feature:
Macro HIGH_SCORE_EN.

Defined:
- Adds outputs HI_DIGIT0[3:0] and HI_DIGIT1[3:0] (best score in BCD) and NEW_HIGH (1 bit).
- The high-score register updates on the edge where the new score exceeds the stored best, i.e. the same edge as the increment.
- NEW_HIGH is sticky, cleared by CLEAR.
- CLEAR does NOT clear the high score. Only RESET zeroes it.

Undefined:
- Ports and registers are absent.
- Behaviour is otherwise identical.

Test Plan:
1. RESET=0 with EAT_IN=1, then release with EAT_IN held 1 for 5 cycles -> DIGIT1/DIGIT0 stay 0/0 and TARGET_HIT=0.
2. 10 single-cycle EAT_IN pulses, 2 cycles apart -> digits step 0/1..0/9, then 1/0. SCORE_BIN=10. TARGET_HIT rises on the edge of the 10th pulse.
3. EAT_IN held high 20 cycles, then low -> exactly one increment. DIGIT0 changes 1 cycle after EAT_IN rises.
4. 105 pulses -> score reaches 9/9, SCORE_BIN=99, SATURATED=1, and stays 99 after pulses 100-105.
5. Score 4/7, CLEAR=1 in the same cycle as a rising EAT_IN, EAT_IN held through CLEAR falling -> score 0/0, TARGET_HIT=0, no increment afterwards.
6. HIGH_SCORE_EN defined: score 23, CLEAR, then score 5 -> HI digits 2/3, NEW_HIGH=0. Continue to 24 -> HI digits 2/4, NEW_HIGH=1.
